// File: rtl/mod_instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-ROM port, decode handshake, redirect and perf outputs.
// master = fetch unit, slave = ROM/decode/branch environment.
interface mod_instruction_fetch_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [29:0]      address;
    logic [31:0]      instruction;
    logic             mem_end;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic             id_ready;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             halted;
    logic [CNT_W-1:0] perf_fetch_cnt;
    logic [CNT_W-1:0] perf_stall_cnt;

    modport master (
        output address,
        input  instruction,
        input  mem_end,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc,
        output halted,
        output perf_fetch_cnt,
        output perf_stall_cnt
    );

    modport slave (
        input  address,
        output instruction,
        output mem_end,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready,
        output redirect_valid,
        output redirect_pc,
        input  halted,
        input  perf_fetch_cnt,
        input  perf_stall_cnt
    );
endinterface

// File: rtl/mod_instruction_fetch_unit.sv
// Instruction fetch unit: PC, ROM addressing, registered fetch output with valid/ready handshake.
// Optional saturating perf counters are built only when FETCH_PERF_CNT_EN is defined.
module mod_instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mod_instruction_fetch_unit_if.master bus
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic advance;
    logic transfer;
    logic stall;

    assign advance  = !if_valid_q || bus.id_ready;
    // A word flushed by a redirect is not handed to decode.
    assign transfer = if_valid_q && bus.id_ready && !bus.redirect_valid;
    assign stall    = if_valid_q && !bus.id_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
            if_valid_d = 1'b0;
            state_d    = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (advance) begin
                        if (!bus.mem_end) begin
                            if_instr_d = bus.instruction;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                            pc_d       = pc_q + 32'd4;
                        end else begin
                            if_valid_d = 1'b0;
                            state_d    = StHalt;
                        end
                    end
                end
                StHalt: begin
                    if (if_valid_q && bus.id_ready) begin
                        if_valid_d = 1'b0;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign bus.address  = pc_q[31:2];
    assign bus.if_valid = if_valid_q;
    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.halted   = (state_q == StHalt) && !if_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (transfer && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt_q;
    assign bus.perf_stall_cnt = stall_cnt_q;
`else
    logic unused_perf;
    assign unused_perf        = transfer ^ stall;
    assign bus.perf_fetch_cnt = '0;
    assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mod_instruction_fetch_unit.sv
// Directed bench for mod_instruction_fetch_unit against a 4-word combinational ROM model.
// Perf-counter expectations follow FETCH_PERF_CNT_EN.
module tb_mod_instruction_fetch_unit;

    localparam int unsigned CNT_W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    logic [31:0] rom [4];

    mod_instruction_fetch_unit_if #(.CNT_W(CNT_W)) bus ();

    mod_instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM: words 0..3, mem_end beyond.
    always_comb begin
        bus.mem_end     = (bus.address > 30'd3);
        bus.instruction = 32'h0;
        if (bus.address <= 30'd3) begin
            bus.instruction = rom[bus.address[1:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string tag, input int exp_fetch, input int exp_stall);
`ifdef FETCH_PERF_CNT_EN
        check_eq({tag, "_fetch_cnt"}, bus.perf_fetch_cnt, exp_fetch);
        check_eq({tag, "_stall_cnt"}, bus.perf_stall_cnt, exp_stall);
`else
        check_eq({tag, "_fetch_cnt_off"}, bus.perf_fetch_cnt, 32'h0);
        check_eq({tag, "_stall_cnt_off"}, bus.perf_stall_cnt, 32'h0);
        if (exp_fetch < 0 || exp_stall < 0) $display("negative expectation %s", tag);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rom[0] = 32'hA000_0013;
        rom[1] = 32'hB000_0093;
        rom[2] = 32'hC000_0113;
        rom[3] = 32'hD000_0193;
        rst_n              = 1'b0;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #23;
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        check_eq("rst_if_instr", bus.if_instr, 32'h0);
        check_eq("rst_if_pc", bus.if_pc, 32'h0);
        check_eq("rst_address", {2'b00, bus.address}, 32'h0);
        check_eq("rst_halted", {31'h0, bus.halted}, 32'h0);
        check_perf("rst", 0, 0);

        // Straight-line run through the 4 words, then halt on mem_end
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("run_valid", {31'h0, bus.if_valid}, 32'h1);
            check_eq("run_if_pc", bus.if_pc, 32'(i * 4));
            check_eq("run_if_instr", bus.if_instr, rom[i]);
        end
        tick();
        check_eq("end_valid", {31'h0, bus.if_valid}, 32'h0);
        tick();
        check_eq("halt_halted", {31'h0, bus.halted}, 32'h1);
        check_eq("halt_address", {2'b00, bus.address}, 32'h4);
        check_eq("halt_valid", {31'h0, bus.if_valid}, 32'h0);
        check_perf("run", 4, 0);

        // Redirect out of HALT with misaligned target 0x3
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3;
        tick();
        bus.redirect_valid = 1'b0;
        check_eq("hredir_address", {2'b00, bus.address}, 32'h0);
        check_eq("hredir_halted", {31'h0, bus.halted}, 32'h0);
        check_eq("hredir_valid", {31'h0, bus.if_valid}, 32'h0);
        tick();
        check_eq("hredir_fetch_valid", {31'h0, bus.if_valid}, 32'h1);
        check_eq("hredir_fetch_pc", bus.if_pc, 32'h0);
        check_eq("hredir_fetch_instr", bus.if_instr, rom[0]);

        // Stall 3 cycles holding if_pc=4
        tick();
        check_eq("pre_stall_pc", bus.if_pc, 32'h4);
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_valid", {31'h0, bus.if_valid}, 32'h1);
            check_eq("stall_if_pc", bus.if_pc, 32'h4);
            check_eq("stall_if_instr", bus.if_instr, rom[1]);
            check_eq("stall_address", {2'b00, bus.address}, 32'h2);
        end
        bus.id_ready = 1'b1;
        tick();
        check_eq("resume_if_pc", bus.if_pc, 32'h8);
        check_eq("resume_if_instr", bus.if_instr, rom[2]);
        check_perf("stall", 6, 3);

        // Redirect to 0x4 while the 0x8 word is waiting; 0x8 is flushed
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4;
        tick();
        bus.redirect_valid = 1'b0;
        check_eq("redir_valid", {31'h0, bus.if_valid}, 32'h0);
        check_eq("redir_address", {2'b00, bus.address}, 32'h1);
        tick();
        check_eq("redir_fetch_valid", {31'h0, bus.if_valid}, 32'h1);
        check_eq("redir_fetch_pc", bus.if_pc, 32'h4);
        check_eq("redir_fetch_instr", bus.if_instr, rom[1]);
        check_eq("redir_pc_next", {2'b00, bus.address}, 32'h2);
        check_perf("redir", 6, 3);

        // Asynchronous reset mid-run (pc=8), away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'h0, bus.if_valid}, 32'h0);
        check_eq("arst_address", {2'b00, bus.address}, 32'h0);
        check_eq("arst_if_pc", bus.if_pc, 32'h0);
        check_eq("arst_if_instr", bus.if_instr, 32'h0);
        check_perf("arst", 0, 0);
        #10;
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_valid", {31'h0, bus.if_valid}, 32'h1);
        check_eq("post_rst_pc", bus.if_pc, 32'h0);
        check_eq("post_rst_instr", bus.if_instr, rom[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
